// File: rtl/llsc_resv_ctrl.sv
// LL/SC reservation controller: tracks the LLbit and reserved granule, resolves SC results
// and drives the LLbit register write port. Optional reservation expiry under LLSC_TIMEOUT_EN.
module llsc_resv_ctrl #(
    parameter int AW      = 32,
    parameter int GRAN    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               ll_req_i,
    input  logic               sc_req_i,
    input  logic [AW-1:0]      mem_addr_i,
    input  logic               snoop_wr_i,
    input  logic [AW-1:0]      snoop_addr_i,
    input  logic               flush_i,
    output logic               sc_done_o,
    output logic               sc_ok_o,
    output logic               we_LLbit_o,
    output logic               wdata_LLbit_o,
    output logic               llbit_o,
    output logic [AW-GRAN-1:0] resv_addr_o,
    output logic               timeout_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RESV = 1'b1
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [AW-GRAN-1:0]  resv_addr_r, resv_addr_nxt_s;
    logic                sc_done_r, sc_ok_r, we_r, wdata_r, timeout_r;
    logic                sc_ok_nxt_s, we_nxt_s, wdata_nxt_s, timeout_nxt_s;
    logic                ll_eff_s, sc_eff_s, in_resv_s, match_s, snoop_hit_s;
    logic                ll_take_s, expire_s;
    logic                unused_s;

    assign ll_eff_s    = ll_req_i & ~stall_i;
    assign sc_eff_s    = sc_req_i & ~stall_i;
    assign in_resv_s   = (state_r == RESV);
    assign match_s     = (mem_addr_i[AW-1:GRAN] == resv_addr_r);
    assign snoop_hit_s = snoop_wr_i & (snoop_addr_i[AW-1:GRAN] == resv_addr_r);

`ifdef LLSC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'sd1);

    logic [CW-1:0] cnt_r;

    // Reservation age: restarts on every accepted LL, counts while reserved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (ll_take_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (in_resv_s) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire_s = in_resv_s & (cnt_r == CNT_LAST);
    assign unused_s = ^{mem_addr_i[GRAN-1:0], snoop_addr_i[GRAN-1:0]};
`else
    // Reservation is held until an explicit clear event; TIMEOUT only sizes the optional counter
    assign expire_s = 1'b0;
    assign unused_s = ^{mem_addr_i[GRAN-1:0], snoop_addr_i[GRAN-1:0], (TIMEOUT < 32'sd1)};
`endif

    // Next state by priority: flush, SC, LL, then snoop/expiry clear
    always_comb begin
        state_nxt_s     = state_r;
        resv_addr_nxt_s = resv_addr_r;
        ll_take_s       = 1'b0;
        if (flush_i) begin
            state_nxt_s = IDLE;
        end else if (sc_eff_s) begin
            state_nxt_s = IDLE;
        end else if (ll_eff_s) begin
            state_nxt_s     = RESV;
            resv_addr_nxt_s = mem_addr_i[AW-1:GRAN];
            ll_take_s       = 1'b1;
        end else if (in_resv_s && (snoop_hit_s || expire_s)) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Result and LLbit write-port values presented one cycle after the deciding cycle
    always_comb begin
        sc_ok_nxt_s   = sc_eff_s & ~flush_i & in_resv_s & match_s & ~snoop_hit_s;
        timeout_nxt_s = expire_s & ~flush_i & ~sc_eff_s & ~ll_eff_s;
        we_nxt_s      = (state_nxt_s != state_r) | (ll_take_s & in_resv_s);
        if (we_nxt_s) begin
            wdata_nxt_s = (state_nxt_s == RESV);
        end else begin
            wdata_nxt_s = wdata_r;
        end
    end

    // State, reservation address and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            resv_addr_r <= {(AW-GRAN){1'b0}};
            sc_done_r   <= 1'b0;
            sc_ok_r     <= 1'b0;
            we_r        <= 1'b0;
            wdata_r     <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            resv_addr_r <= resv_addr_nxt_s;
            sc_done_r   <= sc_eff_s;
            sc_ok_r     <= sc_ok_nxt_s;
            we_r        <= we_nxt_s;
            wdata_r     <= wdata_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign llbit_o       = (state_r == RESV);
    assign resv_addr_o   = resv_addr_r;
    assign sc_done_o     = sc_done_r;
    assign sc_ok_o       = sc_ok_r;
    assign we_LLbit_o    = we_r;
    assign wdata_LLbit_o = wdata_r;
    assign timeout_o     = timeout_r;

endmodule

// File: doc/llsc_resv_ctrl.md
Name: llsc_resv_ctrl

Overview:
- Controller that sequences the LL/SC reservation (LLbit) for the MIPS core's memory stage.
- Tracks the reserved line address and resolves SC success.
- Clears the reservation on conflicting stores, exceptions and ERET.
- Drives the write port of the architectural LLbit register so that register always mirrors the internal reservation state.

Parameters:
- AW, 32, width of the memory byte address.
- GRAN, 2, log2 of the reservation granule in bytes; address bits [GRAN-1:0] are ignored in compares.
- TIMEOUT, 1024, cycle count after which a held reservation expires (used only with LLSC_TIMEOUT_EN).

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  memory-stage stall; ll_req_i and sc_req_i are ignored while high.
- ll_req_i  input  1  LL instruction in memory stage.
- sc_req_i  input  1  SC instruction in memory stage.
- mem_addr_i  input  AW  effective address of the LL/SC.
- snoop_wr_i  input  1  any other store commits this cycle (this core's SW/SB/SH, or an external writer).
- snoop_addr_i  input  AW  address of the snooped store.
- flush_i  input  1  exception taken or ERET executed.
- sc_done_o  output  1  one-cycle pulse: SC result valid.
- sc_ok_o  output  1  SC result (1 = store may commit, rt <= 1); valid when sc_done_o is high.
- we_LLbit_o  output  1  write enable to the LLbit register.
- wdata_LLbit_o  output  1  write data to the LLbit register.
- llbit_o  output  1  current reservation state.
- resv_addr_o  output  AW-GRAN  reserved granule address.
- timeout_o  output  1  one-cycle pulse: reservation expired (tied to 0 without LLSC_TIMEOUT_EN).

Behaviour:
- States: IDLE (llbit_o = 0), RESV (llbit_o = 1). The state register updates on the rising edge.
- Reset (async, rst_n = 0): state IDLE, resv_addr_o = 0, and every other output = 0. The timeout counter is also cleared.
- Effective requests: ll_eff = ll_req_i & ~stall_i, sc_eff = sc_req_i & ~stall_i. flush_i and snoop_wr_i are never gated by stall.
- Match: match = (mem_addr_i[AW-1:GRAN] == resv_addr_o); snoop_hit = snoop_wr_i & (snoop_addr_i[AW-1:GRAN] == resv_addr_o).
- Priority per cycle, highest first: flush, sc, ll, snoop/timeout.
  - flush_i: next state IDLE.
  - sc_eff: next state IDLE. On the next cycle assert sc_done_o = 1 and sc_ok_o = (state == RESV) & match & ~snoop_hit, all evaluated in the request cycle.
  - ll_eff: next state RESV and resv_addr_o <= mem_addr_i[AW-1:GRAN], taken from either state. A snoop to the same granule in the same cycle does not cancel it.
  - snoop_hit in RESV: next state IDLE.
- sc_eff and ll_eff together is illegal. SC wins and LL is dropped.
- flush_i with sc_eff in the same cycle: sc_done_o = 1 and sc_ok_o = 0 next cycle, so the flushed SC still gets a result.
- SC with stall_i high: no action and no sc_done_o. The pipeline re-presents the SC after the stall.
- resv_addr_o holds its value in IDLE and changes only on ll_eff.
- LLbit write port: we_LLbit_o = 1 for one cycle following every edge where the state changes. wdata_LLbit_o then equals the new state.
  - Repeated LL while already in RESV re-writes: we_LLbit_o = 1 and wdata_LLbit_o = 1.
  - Otherwise we_LLbit_o = 0 and wdata_LLbit_o holds its last value.
- Latency: LL to llbit_o = 1 is 1 cycle. SC to sc_done_o is 1 cycle. Clear events to llbit_o = 0 are 1 cycle.
- Reset asserted mid-sequence (e.g. between SC and sc_done_o): the result pulse is lost and outputs go to reset values immediately.

Optional Feature:
- Macro: LLSC_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT) + 1 bits clears on every entry to RESV (including a re-LL) and increments each cycle in RESV.
  - When it reaches TIMEOUT-1 with no higher-priority event, next state is IDLE and timeout_o pulses for 1 cycle in the same cycle as the we_LLbit_o write (wdata 0).
  - Timeout has the same priority as snoop; an SC arriving in the expiry cycle still evaluates against RESV.
- Undefined: no counter exists, timeout_o is tied to 0, and the reservation is held indefinitely.

Test Plan:
- Reset, then LL at 0x1000 and SC at 0x1000 four cycles later -> llbit_o = 1 at cycle+1. sc_done_o = 1 and sc_ok_o = 1. llbit_o = 0 after the SC. we_LLbit_o pulses twice (wdata 1, then 0).
- LL at 0x1000, snoop store at 0x1002 (same granule), then SC at 0x1000 -> llbit_o clears the cycle after the snoop and sc_ok_o = 0. Repeat with a snoop at 0x1004 -> sc_ok_o = 1.
- LL at 0x2000, then SC at 0x2004 -> sc_done_o = 1 and sc_ok_o = 0. resv_addr_o stays 0x800 (GRAN = 2).
- LL in RESV with flush_i in the same cycle -> state IDLE and no write with wdata 1. SC with flush_i together -> sc_done_o = 1 and sc_ok_o = 0.
- SC held with stall_i = 1 for 3 cycles, then released -> sc_done_o pulses exactly once, 1 cycle after release. ll_req_i + sc_req_i together -> SC result given and llbit_o = 0.
- With LLSC_TIMEOUT_EN and TIMEOUT = 8: LL, then idle 8 cycles -> timeout_o pulses on cycle 8 after LL and llbit_o = 0. A re-LL at cycle 5 pushes expiry to cycle 13.
